// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
//   Shares one combinational AddSub unit between two requesters. Arbitration
//   is round-robin. The 4-bit command is decoded into the adder mode. Operands
//   are launched to the AddSub, the block waits SETTLE edges, then captures the
//   sum, carry and overflow. The granted requester gets a one-cycle done pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/1                  request level from each requester
//   cmd0/1, a0/1, b0/1      command and operands, held until the matching gnt
//   gnt0/1                  one-cycle pulse: operands accepted
//   done0/1                 one-cycle pulse: result/carry/ovf/err are valid
//   au_a, au_b, au_mode     operands and mode (0 = add, 1 = sub) to the AddSub
//   au_sum, au_carry, au_ovf  AddSub results (sum is already sign-extended)
//   result, carry_out, ovf_out  captured results, held until the next capture
//   err_out                 last transaction carried an illegal command
//   busy                    high while an operation is in flight
// ---------------------------------------------------------------------------
module addsub_arbiter #(
  parameter int         WIDTH   = 16,
  parameter int         SETTLE  = 2,
  parameter logic [3:0] ADD_CMD = 4'b0001,
  parameter logic [3:0] SUB_CMD = 4'b0101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [3:0]           cmd0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  output logic                 gnt0,
  output logic                 done0,
  input  logic                 req1,
  input  logic [3:0]           cmd1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt1,
  output logic                 done1,
  output logic [WIDTH-1:0]     au_a,
  output logic [WIDTH-1:0]     au_b,
  output logic                 au_mode,
  input  logic [2*WIDTH-1:0]   au_sum,
  input  logic                 au_carry,
  input  logic                 au_ovf,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry_out,
  output logic                 ovf_out,
  output logic                 err_out,
  output logic                 busy
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            owner;
  logic            last_grant;
  logic            illegal;

  // Arbitration decision and the winner's inputs.
  logic             pick;
  logic [3:0]       sel_cmd;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    pick    = 1'b0;
    sel_cmd = cmd0;
    sel_a   = a0;
    sel_b   = b0;
    // On a tie the requester that was not served last wins.
    if (req0 && req1) pick = ~last_grant;
    else              pick = req1;
    if (pick) begin
      sel_cmd = cmd1;
      sel_a   = a1;
      sel_b   = b1;
    end
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register is reset, including the operand/result registers;
      // there is no memory array here that would make that costly.
      state      <= IDLE;
      counter    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
      illegal    <= 1'b0;
      au_a       <= '0;
      au_b       <= '0;
      au_mode    <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      ovf_out    <= 1'b0;
      err_out    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Handshake strobes are single-cycle pulses.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;

      case (state)
        IDLE: begin
          // With no request the AddSub operands are left untouched.
          if (req0 || req1) begin
            gnt0    <= ~pick;
            gnt1    <= pick;
            owner   <= pick;
            au_a    <= sel_a;
            au_b    <= sel_b;
            counter <= CW'(SETTLE);
            state   <= RUN;
            busy    <= 1'b1;
            if (sel_cmd == ADD_CMD) begin
              au_mode <= 1'b0;
              illegal <= 1'b0;
            end else if (sel_cmd == SUB_CMD) begin
              au_mode <= 1'b1;
              illegal <= 1'b0;
            end else begin
              // Mode is left as it was; the result is forced to zero at capture.
              illegal <= 1'b1;
            end
          end
        end

        RUN: begin
          counter <= counter - 1'b1;
          if (counter == CW'(1)) begin
            if (illegal) begin
              result    <= '0;
              carry_out <= 1'b0;
              ovf_out   <= 1'b0;
              err_out   <= 1'b1;
            end else begin
              result    <= au_sum;
              carry_out <= au_carry;
              ovf_out   <= au_ovf;
              err_out   <= 1'b0;
            end
            done0      <= ~owner;
            done1      <= owner;
            last_grant <= owner;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
//   Self-checking bench for addsub_arbiter. A behavioural AddSub drives au_*.
//   Requesters are modelled as pending transactions; the expected winner, mode,
//   latency and captured values come from a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

  localparam int         SETTLE  = 2;
  localparam logic [3:0] ADD_CMD = 4'b0001;
  localparam logic [3:0] SUB_CMD = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  cmd0, cmd1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] au_a, au_b;
  logic        au_mode;
  logic [31:0] au_sum;
  logic        au_carry, au_ovf;
  logic [31:0] result;
  logic        carry_out, ovf_out, err_out, busy;

  addsub_arbiter #(.WIDTH(16), .SETTLE(SETTLE), .ADD_CMD(ADD_CMD), .SUB_CMD(SUB_CMD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .cmd1(cmd1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .au_a(au_a), .au_b(au_b), .au_mode(au_mode),
    .au_sum(au_sum), .au_carry(au_carry), .au_ovf(au_ovf),
    .result(result), .carry_out(carry_out), .ovf_out(ovf_out),
    .err_out(err_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 16-bit add/sub: sign-extended sum, carry out of bit 15,
  // overflow judged from the mathematically exact signed result.
  function automatic void addsub_ref(input logic [15:0] a, input logic [15:0] b,
                                     input logic m, output logic [31:0] s,
                                     output logic c, output logic v);
    logic [16:0] full;
    int          ideal;
    if (m) begin
      full  = {1'b0, a} + {1'b0, ~b} + 17'd1;
      ideal = int'($signed(a)) - int'($signed(b));
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      ideal = int'($signed(a)) + int'($signed(b));
    end
    s = {{16{full[15]}}, full[15:0]};
    c = full[16];
    v = (ideal > 32767) || (ideal < -32768);
  endfunction

  always_comb begin
    au_sum   = '0;
    au_carry = 1'b0;
    au_ovf   = 1'b0;
    addsub_ref(au_a, au_b, au_mode, au_sum, au_carry, au_ovf);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pending transaction per requester.
  bit          pend [2];
  logic [3:0]  p_cmd [2];
  logic [15:0] p_a [2];
  logic [15:0] p_b [2];

  // Model state.
  int   exp_last = 1;
  logic exp_mode = 1'b0;

  task automatic drive();
    req0 = pend[0]; cmd0 = p_cmd[0]; a0 = p_a[0]; b0 = p_b[0];
    req1 = pend[1]; cmd1 = p_cmd[1]; a1 = p_a[1]; b1 = p_b[1];
  endtask

  task automatic present(input int x, input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b);
    pend[x]  = 1'b1;
    p_cmd[x] = c;
    p_a[x]   = a;
    p_b[x]   = b;
    drive();
  endtask

  function automatic logic [3:0] rand_cmd();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4)      return ADD_CMD;
    else if (r < 8) return SUB_CMD;
    else            return 4'($urandom);
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_data"}, {32'd0, au_a, au_b, result}, 96'd0);
    check({tag, "_ctl"}, {87'd0, au_mode, carry_out, ovf_out, err_out, gnt0, gnt1,
                          done0, done1, busy}, 96'd0);
  endtask

  // Serve one transaction: called on a negedge with requests already driven.
  // If refill is set the winner immediately presents a new random operation.
  task automatic serve(input bit refill);
    int          w, n;
    bit          stray;
    logic [3:0]  c;
    logic [15:0] a, b;
    logic [31:0] e_res;
    logic        e_c, e_v, e_err;

    w = (pend[0] && pend[1]) ? 1 - exp_last : (pend[1] ? 1 : 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 10);
    check("gnt_wait", 96'(n), 96'd1);
    check("gnt_id", {94'd0, gnt1, gnt0}, (w == 1) ? 96'd2 : 96'd1);
    c = p_cmd[w]; a = p_a[w]; b = p_b[w];
    check("au_ops", {64'd0, au_a, au_b}, {64'd0, a, b});

    e_err = !(c == ADD_CMD || c == SUB_CMD);
    if (!e_err) exp_mode = (c == SUB_CMD);
    check("au_mode", 96'(au_mode), 96'(exp_mode));
    check("busy_run", 96'(busy), 96'd1);

    if (e_err) begin
      e_res = '0; e_c = 1'b0; e_v = 1'b0;
    end else begin
      addsub_ref(a, b, exp_mode, e_res, e_c, e_v);
    end

    if (refill) present(w, rand_cmd(), 16'($urandom), 16'($urandom));
    else begin
      pend[w] = 1'b0;
      drive();
    end

    n = 0;
    stray = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!(done0 || done1) && (gnt0 || gnt1)) stray = 1'b1;
    end while (!(done0 || done1) && n < 10);
    check("no_gnt_in_run", 96'(stray), 96'd0);
    check("latency", 96'(n), 96'(SETTLE));
    check("done_id", {94'd0, done1, done0}, (w == 1) ? 96'd2 : 96'd1);
    check("capture", {61'd0, result, carry_out, ovf_out, err_out},
                     {61'd0, e_res, e_c, e_v, e_err});
    check("busy_idle", 96'(busy), 96'd0);
    exp_last = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_cmd[0] = '0; p_cmd[1] = '0;
    p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0;
    drive();
    rst_n = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    check_cleared("reset_held");
    rst_n = 1'b1;

    // 1: simple add.
    present(0, ADD_CMD, 16'd6, 16'd1);
    serve(0);
    check("t1_result", 96'(result), 96'h7);

    // 2: subtract both ways.
    present(1, SUB_CMD, 16'd6, 16'd1);
    serve(0);
    check("t2_result", 96'(result), 96'h5);
    present(1, SUB_CMD, 16'd1, 16'd6);
    serve(0);
    check("t2_neg", 96'(result), 96'hFFFFFFFB);

    // 3: both requesting continuously; grants must alternate 0,1,0,1.
    present(0, ADD_CMD, 16'd100, 16'd23);
    present(1, SUB_CMD, 16'd100, 16'd23);
    for (int i = 0; i < 4; i++) begin
      serve(1);
      check("t3_order", 96'(exp_last), 96'(i % 2));
    end
    while (pend[0] || pend[1]) serve(0);

    // 4: illegal command, then a legal one clears err_out.
    present(0, 4'b0011, 16'h1234, 16'h4321);
    serve(0);
    check("t4_err", {63'd0, err_out, result}, {63'd1, 32'd0});
    present(0, ADD_CMD, 16'd2, 16'd3);
    serve(0);
    check("t4_clear", {63'd0, err_out, result}, {63'd0, 32'd5});

    // 5: overflow and carry boundaries.
    present(0, ADD_CMD, 16'h7FFF, 16'h0001);
    serve(0);
    check("t5_ovf", {62'd0, result, carry_out, ovf_out}, {62'd0, 32'hFFFF8000, 1'b0, 1'b1});
    present(0, ADD_CMD, 16'hFFFF, 16'h0001);
    serve(0);
    check("t5_carry", {62'd0, result, carry_out, ovf_out}, {62'd0, 32'h0, 1'b1, 1'b0});

    // Randomized mix of single, contended and illegal requests.
    for (int i = 0; i < 60; i++) begin
      if (!pend[0] && !pend[1]) repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int x = 0; x < 2; x++)
        if (!pend[x] && $urandom_range(0, 1) == 1)
          present(x, rand_cmd(), 16'($urandom), 16'($urandom));
      if (!pend[0] && !pend[1])
        present(int'($urandom_range(0, 1)), rand_cmd(), 16'($urandom), 16'($urandom));
      serve(0);
    end
    while (pend[0] || pend[1]) serve(0);

    // 6: reset in the middle of an operation.
    present(0, ADD_CMD, 16'd3, 16'd4);
    serve(0);
    present(0, ADD_CMD, 16'd5, 16'd5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0 && n < 10);
    check("t6_gnt0", 96'(gnt0), 96'd1);
    pend[0] = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("t6_reset");
    @(negedge clk);
    check_cleared("t6_no_done");
    rst_n = 1'b1;
    exp_last = 1;
    exp_mode = 1'b0;
    present(1, SUB_CMD, 16'd9, 16'd4);
    serve(0);
    check("t6_result", 96'(result), 96'h5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
